// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if
//   Word handshake into the serial frame transmitter.
//   in_valid : producer has a word on in_data
//   in_data  : DATA_W-bit word, sampled by the transmitter only at accept
//   in_ready : transmitter can take a word this cycle
//   master = word producer, slave = transmitter.
interface serial_frame_tx_if #(
   parameter int DATA_W = 4
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Parallel-to-serial frame transmitter. A frame is a low start bit, the
//   DATA_W data bits LSB first, an optional even-parity bit and a high stop
//   bit, every line bit held for BIT_CYCLES clocks.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   VDD, VSS   : power pins of the physical netlist (no logic function)
//   in_if      : word handshake (slave side)
//   tx_out     : serial line, idles high
//   tx_busy    : high from the start bit through the stop bit
//   frame_done : one-cycle pulse during the last cycle of the stop bit
module serial_frame_tx #(
   parameter int DATA_W     = 4,
   parameter int BIT_CYCLES = 4,
   parameter int PARITY_EN  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   inout  wire                  VDD,
   inout  wire                  VSS,
   serial_frame_tx_if.slave     in_if,
   output logic                 tx_out,
   output logic                 tx_busy,
   output logic                 frame_done
);

   localparam int CW = $clog2(BIT_CYCLES) + 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] sh_next;
   logic              par;
   logic              in_ready_q;
   logic              bit_end;
   logic [CW-1:0]     cnt_inc;

   wire unused_pwr = VDD ^ VSS;

   assign bit_end        = (cnt == CNT_LAST);
   assign cnt_inc        = cnt + 1'b1;
   assign sh_next        = shreg >> 1;
   assign in_if.in_ready = in_ready_q;

   // Outputs are registered: every transition loads the line value of the
   // state being entered, so tx_out only moves on bit boundaries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         tx_out     <= 1'b1;
         tx_busy    <= 1'b0;
         frame_done <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               // in_ready comes up one edge after reset release
               in_ready_q <= 1'b1;
               if (in_if.in_valid && in_ready_q) begin
                  shreg      <= in_if.in_data;
                  par        <= ^in_if.in_data;
                  state      <= START;
                  cnt        <= '0;
                  tx_out     <= 1'b0;
                  tx_busy    <= 1'b1;
                  in_ready_q <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= DATA;
                  tx_out  <= shreg[0];
               end else begin
                  cnt <= cnt_inc;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     if (PARITY_EN != 0) begin
                        state  <= PARITY;
                        tx_out <= par;
                     end else begin
                        state      <= STOP;
                        tx_out     <= 1'b1;
                        // a one-cycle stop bit is its own last cycle
                        frame_done <= (BIT_CYCLES == 1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= sh_next;
                     tx_out  <= sh_next[0];
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            PARITY: begin
               if (bit_end) begin
                  cnt        <= '0;
                  state      <= STOP;
                  tx_out     <= 1'b1;
                  frame_done <= (BIT_CYCLES == 1);
               end else begin
                  cnt <= cnt_inc;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt        <= '0;
                  state      <= IDLE;
                  tx_busy    <= 1'b0;
                  in_ready_q <= 1'b1;
               end else begin
                  cnt        <= cnt_inc;
                  frame_done <= (cnt_inc == CNT_LAST);
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               tx_out     <= 1'b1;
               tx_busy    <= 1'b0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
